blob_stats: RTL and testbench

- Consumes the resolved per-pixel label stream produced by the connected-component labeling stage: 6-bit label, raster order, 320x240, qualified by a valid strobe.
- Accumulates per-label bounding box and pixel area over one frame.
- After the frame, emits one record per surviving label through a valid/ready handshake to the downstream overlay/tracking logic.

---
 rtl/blob_stats_pkg.sv | 32 +++
 rtl/blob_stats_if.sv | 49 ++++
 rtl/blob_stats_rec_out.sv | 57 +++++
 rtl/blob_stats.sv | 167 ++++++++++++++++
 tb/tb_blob_stats.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/blob_stats_pkg.sv
// Shared constants, FSM state type and record layout for the blob statistics block.
package blob_stats_pkg;

  localparam int H_RES    = 320;
  localparam int V_RES    = 240;
  localparam int N_LABELS = 64;
  localparam int MIN_AREA = 16;

  localparam int ID_W   = 6;
  localparam int AREA_W = 17;
  localparam int X_W    = 9;
  localparam int Y_W    = 8;
  localparam int SUM_W  = 24;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    ACCUM = 2'd1,
    DUMP  = 2'd2
  } state_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [X_W-1:0]    xmin;
    logic [X_W-1:0]    xmax;
    logic [Y_W-1:0]    ymin;
    logic [Y_W-1:0]    ymax;
    logic [AREA_W-1:0] area;
  } blob_rec_t;

  localparam int REC_W = $bits(blob_rec_t);

endpackage

// File: rtl/blob_stats_if.sv
// Record handshake bundle between blob_stats (master) and the overlay/tracking consumer (slave).
// Carries oSUMX/oSUMY only when BLOB_STATS_SUM_EN is defined.
interface blob_stats_if;
  import blob_stats_pkg::*;

  logic              oREC_VALID;
  logic              iREC_READY;
  logic [ID_W-1:0]   oREC_ID;
  logic [X_W-1:0]    oXMIN;
  logic [X_W-1:0]    oXMAX;
  logic [Y_W-1:0]    oYMIN;
  logic [Y_W-1:0]    oYMAX;
  logic [AREA_W-1:0] oAREA;
`ifdef BLOB_STATS_SUM_EN
  logic [SUM_W-1:0]  oSUMX;
  logic [SUM_W-1:0]  oSUMY;
`endif

  modport master (
`ifdef BLOB_STATS_SUM_EN
    output oSUMX,
    output oSUMY,
`endif
    output oREC_VALID,
    output oREC_ID,
    output oXMIN,
    output oXMAX,
    output oYMIN,
    output oYMAX,
    output oAREA,
    input  iREC_READY
  );

  modport slave (
`ifdef BLOB_STATS_SUM_EN
    input  oSUMX,
    input  oSUMY,
`endif
    input  oREC_VALID,
    input  oREC_ID,
    input  oXMIN,
    input  oXMAX,
    input  oYMIN,
    input  oYMAX,
    input  oAREA,
    output iREC_READY
  );

endinterface

// File: rtl/blob_stats_rec_out.sv
// Output register slice: captures one record on load and holds it until the consumer takes it.
// Sum fields exist only when BLOB_STATS_SUM_EN is defined.
module blob_rec_out
  import blob_stats_pkg::*;
(
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             load,
  input  blob_rec_t        rec_in,
`ifdef BLOB_STATS_SUM_EN
  input  logic [SUM_W-1:0] sumx_in,
  input  logic [SUM_W-1:0] sumy_in,
`endif
  blob_stats_if.master     rec
);

  logic      valid_r;
  blob_rec_t rec_r;
`ifdef BLOB_STATS_SUM_EN
  logic [SUM_W-1:0] sumx_r;
  logic [SUM_W-1:0] sumy_r;
`endif

  // Valid is cleared only by an observed transfer, so it never follows ready combinationally.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      valid_r <= 1'b0;
      rec_r   <= {REC_W{1'b0}};
`ifdef BLOB_STATS_SUM_EN
      sumx_r  <= {SUM_W{1'b0}};
      sumy_r  <= {SUM_W{1'b0}};
`endif
    end else if (load) begin
      valid_r <= 1'b1;
      rec_r   <= rec_in;
`ifdef BLOB_STATS_SUM_EN
      sumx_r  <= sumx_in;
      sumy_r  <= sumy_in;
`endif
    end else if (valid_r && rec.iREC_READY) begin
      valid_r <= 1'b0;
    end
  end

  assign rec.oREC_VALID = valid_r;
  assign rec.oREC_ID    = rec_r.id;
  assign rec.oXMIN      = rec_r.xmin;
  assign rec.oXMAX      = rec_r.xmax;
  assign rec.oYMIN      = rec_r.ymin;
  assign rec.oYMAX      = rec_r.ymax;
  assign rec.oAREA      = rec_r.area;
`ifdef BLOB_STATS_SUM_EN
  assign rec.oSUMX      = sumx_r;
  assign rec.oSUMY      = sumy_r;
`endif

endmodule

// File: rtl/blob_stats.sv
// Per-label bounding box and area over one raster frame, then one record per label with
// enough pixels. Defining BLOB_STATS_SUM_EN adds per-label coordinate sums for centroids.
module blob_stats
  import blob_stats_pkg::*;
#(
  parameter int H_RES_P    = H_RES,
  parameter int V_RES_P    = V_RES,
  parameter int MIN_AREA_P = MIN_AREA
) (
  input  logic            iCLK,
  input  logic            iRST,
  input  logic            iDVAL,
  input  logic [ID_W-1:0] iLABEL,
  output logic            oBUSY,
  output logic            oDROP,
  output logic            oFRAME_DONE,
  blob_stats_if.master    rec
);

  localparam logic [X_W-1:0]    X_LAST   = X_W'(H_RES_P - 1);
  localparam logic [Y_W-1:0]    Y_LAST   = Y_W'(V_RES_P - 1);
  localparam logic [ID_W-1:0]   ID_LAST  = ID_W'(N_LABELS - 1);
  localparam logic [AREA_W-1:0] AREA_MIN = AREA_W'(MIN_AREA_P);

  state_t          state_r, state_nxt_s;
  logic [ID_W-1:0] idx_r, idx_nxt_s;
  logic [X_W-1:0]  x_r;
  logic [Y_W-1:0]  y_r;
  logic            busy_r, drop_r, done_r;
  logic            done_s, load_s, pix_s, frame_end_s, keep_s, xfer_s;
  blob_rec_t       rec_s;

  logic [AREA_W-1:0] area_r [N_LABELS];
  logic [X_W-1:0]    xmin_r [N_LABELS];
  logic [X_W-1:0]    xmax_r [N_LABELS];
  logic [Y_W-1:0]    ymin_r [N_LABELS];
  logic [Y_W-1:0]    ymax_r [N_LABELS];
`ifdef BLOB_STATS_SUM_EN
  logic [SUM_W-1:0]  sumx_r [N_LABELS];
  logic [SUM_W-1:0]  sumy_r [N_LABELS];
`endif

  assign pix_s       = iDVAL && (state_r == ACCUM) && !iRST;
  assign frame_end_s = pix_s && (x_r == X_LAST) && (y_r == Y_LAST);
  assign keep_s      = (area_r[idx_r] >= AREA_MIN);
  assign xfer_s      = rec.oREC_VALID && rec.iREC_READY;
  assign rec_s       = '{id: idx_r, xmin: xmin_r[idx_r], xmax: xmax_r[idx_r],
                         ymin: ymin_r[idx_r], ymax: ymax_r[idx_r], area: area_r[idx_r]};

  // Next-state and sweep index: clear sweep, pixel accumulation, record dump.
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    load_s      = 1'b0;
    done_s      = 1'b0;
    case (state_r)
      CLEAR: begin
        if (idx_r == ID_LAST) begin
          state_nxt_s = ACCUM;
          idx_nxt_s   = 6'd0;
        end else begin
          idx_nxt_s   = idx_r + 6'd1;
        end
      end
      ACCUM: begin
        if (frame_end_s) begin
          state_nxt_s = DUMP;
          idx_nxt_s   = 6'd1;
        end else begin
          idx_nxt_s   = idx_r;
        end
      end
      DUMP: begin
        // A kept entry is loaded once, then the index waits for its transfer.
        if (keep_s && !rec.oREC_VALID) begin
          load_s = 1'b1;
        end else if (!keep_s || xfer_s) begin
          if (idx_r == ID_LAST) begin
            state_nxt_s = CLEAR;
            idx_nxt_s   = 6'd0;
            done_s      = 1'b1;
          end else begin
            idx_nxt_s   = idx_r + 6'd1;
          end
        end else begin
          load_s = 1'b0;
        end
      end
      default: begin
        state_nxt_s = CLEAR;
        idx_nxt_s   = 6'd0;
      end
    endcase
  end

  // FSM state, status flags and raster position.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_r <= CLEAR;
      idx_r   <= 6'd0;
      x_r     <= 9'd0;
      y_r     <= 8'd0;
      busy_r  <= 1'b1;
      drop_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      idx_r   <= idx_nxt_s;
      busy_r  <= (state_nxt_s != ACCUM);
      drop_r  <= drop_r | (iDVAL && (state_r != ACCUM));
      done_r  <= done_s;
      if (state_r == CLEAR) begin
        x_r <= 9'd0;
        y_r <= 8'd0;
      end else if (pix_s) begin
        if (x_r == X_LAST) begin
          x_r <= 9'd0;
          y_r <= (y_r == Y_LAST) ? 8'd0 : y_r + 8'd1;
        end else begin
          x_r <= x_r + 9'd1;
        end
      end
    end
  end

  // Label table: one entry cleared per CLEAR cycle, single-cycle read-modify-write per pixel.
  always_ff @(posedge iCLK) begin
    if (state_r == CLEAR) begin
      area_r[idx_r] <= 17'd0;
      xmin_r[idx_r] <= 9'd511;
      xmax_r[idx_r] <= 9'd0;
      ymin_r[idx_r] <= 8'd255;
      ymax_r[idx_r] <= 8'd0;
`ifdef BLOB_STATS_SUM_EN
      sumx_r[idx_r] <= 24'd0;
      sumy_r[idx_r] <= 24'd0;
`endif
    end else if (pix_s && (iLABEL != 6'd0)) begin
      area_r[iLABEL] <= area_r[iLABEL] + 17'd1;
      xmin_r[iLABEL] <= (x_r < xmin_r[iLABEL]) ? x_r : xmin_r[iLABEL];
      xmax_r[iLABEL] <= (x_r > xmax_r[iLABEL]) ? x_r : xmax_r[iLABEL];
      ymin_r[iLABEL] <= (y_r < ymin_r[iLABEL]) ? y_r : ymin_r[iLABEL];
      ymax_r[iLABEL] <= (y_r > ymax_r[iLABEL]) ? y_r : ymax_r[iLABEL];
`ifdef BLOB_STATS_SUM_EN
      sumx_r[iLABEL] <= sumx_r[iLABEL] + {15'd0, x_r};
      sumy_r[iLABEL] <= sumy_r[iLABEL] + {16'd0, y_r};
`endif
    end
  end

  blob_rec_out u_rec_out (
    .iCLK    (iCLK),
    .iRST    (iRST),
    .load    (load_s),
    .rec_in  (rec_s),
`ifdef BLOB_STATS_SUM_EN
    .sumx_in (sumx_r[idx_r]),
    .sumy_in (sumy_r[idx_r]),
`endif
    .rec     (rec)
  );

  assign oBUSY       = busy_r;
  assign oDROP       = drop_r;
  assign oFRAME_DONE = done_r;

endmodule

// File: tb/tb_blob_stats.sv
// Self-checking bench for blob_stats on a reduced 112x64 raster; expected records come from
// scanning a label map held in the bench. Define BLOB_STATS_SUM_EN to also check coordinate sums.
module tb_blob_stats;
  import blob_stats_pkg::*;

  localparam int HR   = 112;
  localparam int VR   = 64;
  localparam int MINA = 16;

  logic            iCLK;
  logic            iRST;
  logic            iDVAL;
  logic [ID_W-1:0] iLABEL;
  logic            oBUSY;
  logic            oDROP;
  logic            oFRAME_DONE;

  blob_stats_if rec_if ();

  blob_stats #(.H_RES_P(HR), .V_RES_P(VR), .MIN_AREA_P(MINA)) dut (
    .iCLK        (iCLK),
    .iRST        (iRST),
    .iDVAL       (iDVAL),
    .iLABEL      (iLABEL),
    .oBUSY       (oBUSY),
    .oDROP       (oDROP),
    .oFRAME_DONE (oFRAME_DONE),
    .rec         (rec_if)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  typedef struct {
    blob_rec_t r;
    int        sx;
    int        sy;
  } exp_t;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [5:0] lmap [VR][HR];
  exp_t       exp_q [$];

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_rec(input string tag, input blob_rec_t obs, input blob_rec_t exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed id=%0d x=%0d..%0d y=%0d..%0d area=%0d expected id=%0d x=%0d..%0d y=%0d..%0d area=%0d",
             tag, obs.id, obs.xmin, obs.xmax, obs.ymin, obs.ymax, obs.area,
             exp.id, exp.xmin, exp.xmax, exp.ymin, exp.ymax, exp.area);
    end
  endtask

  function automatic blob_rec_t cur_rec();
    blob_rec_t r;
    r.id   = rec_if.oREC_ID;
    r.xmin = rec_if.oXMIN;
    r.xmax = rec_if.oXMAX;
    r.ymin = rec_if.oYMIN;
    r.ymax = rec_if.oYMAX;
    r.area = rec_if.oAREA;
    return r;
  endfunction

  task automatic clear_map();
    for (int y = 0; y < VR; y++)
      for (int x = 0; x < HR; x++)
        lmap[y][x] = 6'd0;
  endtask

  task automatic rect(input int l, input int x0, input int x1, input int y0, input int y1);
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++)
        lmap[y][x] = 6'(l);
  endtask

  task automatic random_map();
    int w, h, x0, y0;
    clear_map();
    for (int k = 0; k < 14; k++) begin
      w  = int'($urandom_range(1, 12));
      h  = int'($urandom_range(1, 12));
      x0 = int'($urandom_range(0, HR - w));
      y0 = int'($urandom_range(0, VR - h));
      rect(int'($urandom_range(1, 63)), x0, x0 + w - 1, y0, y0 + h - 1);
    end
  endtask

  // Reference: scan the whole map per label, keep labels with enough pixels, ascending id.
  task automatic build_exp();
    int   a [N_LABELS];
    int   xl [N_LABELS];
    int   xh [N_LABELS];
    int   yl [N_LABELS];
    int   yh [N_LABELS];
    int   sx [N_LABELS];
    int   sy [N_LABELS];
    int   l;
    exp_t e;
    for (int i = 0; i < N_LABELS; i++) begin
      a[i] = 0; xl[i] = 511; xh[i] = 0; yl[i] = 255; yh[i] = 0; sx[i] = 0; sy[i] = 0;
    end
    for (int y = 0; y < VR; y++)
      for (int x = 0; x < HR; x++) begin
        l = int'(lmap[y][x]);
        if (l != 0) begin
          a[l]++;
          if (x < xl[l]) xl[l] = x;
          if (x > xh[l]) xh[l] = x;
          if (y < yl[l]) yl[l] = y;
          if (y > yh[l]) yh[l] = y;
          sx[l] += x;
          sy[l] += y;
        end
      end
    exp_q.delete();
    for (int i = 1; i < N_LABELS; i++) begin
      if (a[i] >= MINA) begin
        e.r.id   = 6'(i);
        e.r.xmin = 9'(xl[i]);
        e.r.xmax = 9'(xh[i]);
        e.r.ymin = 8'(yl[i]);
        e.r.ymax = 8'(yh[i]);
        e.r.area = 17'(a[i]);
        e.sx     = sx[i];
        e.sy     = sy[i];
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic drive_frame(input int stop_after);
    int cnt = 0;
    for (int y = 0; y < VR; y++) begin
      for (int x = 0; x < HR; x++) begin
        if (stop_after >= 0 && cnt == stop_after) return;
        if ($urandom_range(0, 7) == 0) begin
          iDVAL = 1'b0;
          tick();
        end
        if (x == 0) chk("busy_in_accum", 32'(oBUSY), 32'd0);
        iDVAL  = 1'b1;
        iLABEL = lmap[y][x];
        tick();
        cnt++;
      end
    end
    iDVAL = 1'b0;
  endtask

  // Called at the sample right after the final pixel's clock edge.
  task automatic run_dump(input int stall_id, input bit poke, input bit empty);
    int        n           = 0;
    int        first_valid = -1;
    int        first_id;
    int        stall_left  = 20;
    bit        seen_done   = 1'b0;
    bit        have_snap   = 1'b0;
    blob_rec_t obs, snap;
    exp_t      e;
    snap     = {REC_W{1'b0}};
    first_id = (exp_q.size() > 0) ? int'(exp_q[0].r.id) : -1;
    while (n < 3000 && !seen_done) begin
      obs   = cur_rec();
      iDVAL = 1'b0;
      if (oFRAME_DONE === 1'b1) begin
        seen_done = 1'b1;
      end else begin
        if (poke && n >= 2 && n < 40) begin
          iDVAL  = 1'b1;
          iLABEL = 6'd9;
        end
        if (rec_if.oREC_VALID === 1'b1) begin
          if (first_valid < 0) first_valid = n;
          if (int'(obs.id) == stall_id && stall_left > 0) begin
            if (have_snap) chk_rec("hold_stable", obs, snap);
            else begin
              snap      = obs;
              have_snap = 1'b1;
            end
            stall_left--;
            rec_if.iREC_READY = 1'b0;
          end else begin
            rec_if.iREC_READY = ($urandom_range(0, 2) != 0);
            if (rec_if.iREC_READY) begin
              if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $error("FAIL extra_record: observed id %0d expected none", obs.id);
              end else begin
                e = exp_q.pop_front();
                chk_rec("record", obs, e.r);
`ifdef BLOB_STATS_SUM_EN
                chk("sumx", 32'(rec_if.oSUMX), 32'(e.sx));
                chk("sumy", 32'(rec_if.oSUMY), 32'(e.sy));
`endif
              end
            end
          end
        end else begin
          rec_if.iREC_READY = 1'($urandom_range(0, 1));
        end
        tick();
        n++;
      end
    end
    iDVAL             = 1'b0;
    rec_if.iREC_READY = 1'b0;
    chk("done_seen", 32'(seen_done), 32'd1);
    chk("records_left", 32'(exp_q.size()), 32'd0);
    if (empty) chk("done_latency", 32'(n), 32'd63);
    if (first_id > 0) chk("first_latency", 32'(first_valid), 32'(first_id));
    if (stall_id > 0) chk("stall_cycles", 32'(stall_left), 32'd0);
  endtask

  task automatic count_busy(input bit poke);
    int n          = 0;
    int extra_done = 0;
    while (oBUSY === 1'b1 && n < 200) begin
      if (poke) begin
        iDVAL  = 1'b1;
        iLABEL = 6'd5;
      end
      if (n > 0 && oFRAME_DONE === 1'b1) extra_done++;
      tick();
      n++;
    end
    iDVAL = 1'b0;
    chk("busy_cycles", 32'(n), 32'd64);
    chk("done_single", 32'(extra_done), 32'd0);
  endtask

  task automatic check_reset_vals();
    chk("rst_busy", 32'(oBUSY), 32'd1);
    chk("rst_drop", 32'(oDROP), 32'd0);
    chk("rst_done", 32'(oFRAME_DONE), 32'd0);
    chk("rst_valid", 32'(rec_if.oREC_VALID), 32'd0);
    chk_rec("rst_fields", cur_rec(), {REC_W{1'b0}});
`ifdef BLOB_STATS_SUM_EN
    chk("rst_sumx", 32'(rec_if.oSUMX), 32'd0);
    chk("rst_sumy", 32'(rec_if.oSUMY), 32'd0);
`endif
  endtask

  initial begin
    iRST              = 1'b1;
    iDVAL             = 1'b0;
    iLABEL            = 6'd0;
    rec_if.iREC_READY = 1'b0;
    tick();
    check_reset_vals();
    iRST = 1'b0;
    count_busy(1'b0);

    // Empty frame: background only.
    clear_map();
    build_exp();
    drive_frame(-1);
    run_dump(0, 1'b0, 1'b1);
    count_busy(1'b0);

    // Directed frame: sum pattern, threshold edge (15 vs 16), square, stalled record, drops in DUMP.
    clear_map();
    lmap[0][0] = 6'd1;
    lmap[0][2] = 6'd1;
    lmap[2][1] = 6'd1;
    rect(1, 0, 12, 3, 3);
    rect(3, 0, 14, 5, 5);
    rect(7, 20, 35, 10, 10);
    rect(2, 40, 43, 20, 24);
    rect(9, 60, 64, 30, 34);
    rect(5, 100, 109, 50, 59);
    build_exp();
    chk("drop_clear", 32'(oDROP), 32'd0);
    drive_frame(-1);
    run_dump(2, 1'b1, 1'b0);
    chk("drop_set", 32'(oDROP), 32'd1);
    count_busy(1'b1);

    // Random frame after the drops: table and position must be clean.
    random_map();
    build_exp();
    drive_frame(-1);
    run_dump(0, 1'b0, 1'b0);
    chk("drop_sticky", 32'(oDROP), 32'd1);
    count_busy(1'b0);

    // Reset in the middle of accumulation.
    random_map();
    drive_frame(3000);
    iRST  = 1'b1;
    iDVAL = 1'b1;
    tick();
    check_reset_vals();
    iRST  = 1'b0;
    iDVAL = 1'b0;
    count_busy(1'b0);

    random_map();
    build_exp();
    drive_frame(-1);
    run_dump(0, 1'b0, 1'b0);
    chk("drop_after_reset", 32'(oDROP), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
